// File: rtl/imem_loader.sv
// imem_loader: byte-stream to instruction-memory writer holding the core in reset until loaded; optional CHECKSUM_EN adds a trailing XOR check byte
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wd,
    output logic              core_rst,
    output logic              done,
    output logic              err
);
    localparam int MAX_WORDS = 1 << ADDR_W;
`ifdef CHECKSUM_EN
    typedef enum logic [2:0] {HDR0, HDR1, LOAD, CHK, DONE, ERR} state_t;
    localparam state_t FIN = CHK;
    logic [7:0] acc;
`else
    typedef enum logic [2:0] {HDR0, HDR1, LOAD, DONE, ERR} state_t;
    localparam state_t FIN = DONE;
`endif
    state_t state, state_d;
    logic [7:0] len_lo;
    logic [15:0] len;
    logic [ADDR_W:0] n, idx;
    logic [1:0] lane;
    logic [23:0] sh;
    logic take, load_take, word_take, last_word;
    assign in_ready = state != DONE && state != ERR;
    assign core_rst = state != DONE;
    assign done = state == DONE;
    assign err = state == ERR;
    assign take = in_valid && in_ready;
    assign len = {in_data, len_lo};
    // idx == n marks the payload as complete; further bytes in LOAD are ignored
    assign load_take = take && state == LOAD && idx != n;
    assign word_take = load_take && lane == 2'd3;
    assign last_word = word_take && idx + 1'b1 == n;
    always_comb begin
        state_d = state;
        case (state)
            HDR0: state_d = take ? HDR1 : HDR0;
            HDR1: if (take) state_d = len == 16'd0 ? FIN : 32'(len) > MAX_WORDS ? ERR : LOAD;
`ifdef CHECKSUM_EN
            LOAD: state_d = last_word ? CHK : LOAD;
            CHK:  if (take) state_d = in_data == acc ? DONE : ERR;
`else
            // one drain cycle so done rises the cycle after the final write strobe
            LOAD: state_d = idx == n ? DONE : LOAD;
`endif
            default: state_d = state;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HDR0;
            len_lo   <= '0;
            n        <= '0;
            idx      <= '0;
            lane     <= '0;
            sh       <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_wd   <= '0;
`ifdef CHECKSUM_EN
            acc      <= '0;
`endif
        end else begin
            state  <= state_d;
            mem_we <= word_take;
            if (take && state == HDR0) len_lo <= in_data;
            if (take && state == HDR1) n <= len[ADDR_W:0];
            if (load_take) begin
                lane <= lane + 2'd1;
                sh   <= {in_data, sh[23:8]};
`ifdef CHECKSUM_EN
                acc  <= acc ^ in_data;
`endif
            end
            if (word_take) begin
                mem_wd   <= {in_data, sh};
                mem_addr <= idx[ADDR_W-1:0];
                idx      <= idx + 1'b1;
            end
        end
    end
endmodule
